alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- 32-bit integer ALU for the datapath execute stage.
- Provides two-operand arithmetic/logic, immediate forms and barrel shifts, selected by a 3-bit opcode.
- Combinational compute core feeding a single output register, so the result is registered with 1-cycle latency.
- A valid bit travels alongside the result.

Parameters:
- DATA_W, 32: operand/result width.
- IMM_W, 16: immediate width; must equal DATA_W/2.
- SH_W, 5: shift-amount width; must equal clog2(DATA_W).
- OP_W, 3: opcode width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/opcode valid this cycle.
- in1  in  DATA_W  operand A, two's complement.
- in2  in  DATA_W  operand B, two's complement.
- imm  in  IMM_W  immediate.
- sh  in  SH_W  shift amount, unsigned.
- alu_op  in  OP_W  operation select.
- out_valid  out  1  result valid.
- result  out  DATA_W  registered result.

Behaviour:
- Opcodes:
  - 0 ADD: in1+in2.
  - 1 SUB: in1-in2.
  - 2 ADDI: in1+sext(imm).
  - 3 OR: in1|in2.
  - 4 ORI: in1|zext(imm).
  - 5 SLL: in1<<sh, zero fill.
  - 6 SRL: in1>>sh, logical, zero fill.
  - 7 SRA: in1>>>sh, sign fill from in1[31].
- Arithmetic rules:
  - All arithmetic is modulo 2^DATA_W; carry-out is discarded.
  - ADDI sign-extends imm[15] into bits 31:16.
  - ORI zero-extends imm.
  - The shift amount is sh only; in2 and imm are ignored for shifts. sh=0 passes in1 unchanged.
- Timing:
  - On each rising clk edge, result <= f(alu_op, operands) and out_valid <= in_valid.
  - Latency is exactly 1 cycle; throughput is one op per cycle; there is no backpressure.
- in_valid=0: result still updates with the computed value, out_valid=0. Consumers ignore result when out_valid=0.
- Reset:
  - rst asserted at any time, including mid-stream, immediately clears result=0 and out_valid=0.
  - The first capture happens on the first clk edge after rst deasserts.
- All 8 opcode encodings are defined, so there is no illegal-op case.
- X on inputs with in_valid=1 is a bench error, not handled.

Optional Feature:
- Macro ALU_STATUS_FLAGS_EN.
- Defined: adds output ports zero (1), ovf (1) and carry (1), all registered with result and cleared on rst.
  - zero = (result==0), for all ops.
  - ovf = signed overflow for ADD/SUB/ADDI (operand signs equal for add, or differing for sub, and result sign differs); 0 for all other ops.
  - carry = unsigned carry-out of ADD/ADDI, borrow-not for SUB; 0 for all other ops.
- Undefined: these ports do not exist, and behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - opcode constants ALU_ADD..ALU_SRA (values 0..7) as an OP_W-wide enum typedef;
  - default widths DATA_W, IMM_W, SH_W.
- One sub-module, alu_shifter: combinational SLL/SRL/SRA on in1 by sh, selected by a 2-bit mode.
- Adder, OR, immediate extension and output register stay in alu_unit.

Test Plan:
- Base vector in1=5, in2=-3, imm=-12 (0xFFF4), sh=2, in_valid=1, sweeping alu_op 0..7. One cycle later result must be:
  - ADD 0x00000002
  - SUB 0x00000008
  - ADDI 0xFFFFFFF9
  - OR 0xFFFFFFFD
  - ORI 0x0000FFF5
  - SLL 0x00000014
  - SRL 0x00000001
  - SRA 0x00000001
- Sign-fill shifts: in1=0x80000000, sh=4 -> SRL 0x08000000, SRA 0xF8000000, SLL 0x00000000. With sh=0 and SRA -> 0x80000000.
- Overflow/wrap: ADD in1=0x7FFFFFFF, in2=1 -> result 0x80000000. With ALU_STATUS_FLAGS_EN: ovf=1, carry=0, zero=0. SUB 5-5 -> result 0, zero=1.
- Latency/valid:
  - Pulse in_valid for one cycle: out_valid is high exactly one cycle later, for one cycle.
  - Back-to-back ops on consecutive cycles: each result appears one cycle after its inputs.
- Async reset: assert rst between clock edges while out_valid=1 and result=0xFFFFFFF9. result=0 and out_valid=0 immediately, without waiting for a clk edge, and hold through rst.
- Immediate extension: ORI with imm=0x8000, in1=0 -> 0x00008000. ADDI with imm=0x8000, in1=0 -> 0xFFFF8000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/shift-mode encodings and default widths for the 32-bit ALU.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int SH_W   = 5;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_ADDI = 3'd2,
        ALU_OR   = 3'd3,
        ALU_ORI  = 3'd4,
        ALU_SLL  = 3'd5,
        ALU_SRL  = 3'd6,
        ALU_SRA  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } sh_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logarithmic barrel shifter: SLL / SRL / SRA of in1 by sh.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int SH_W   = alu_pkg::SH_W
) (
    input  logic [DATA_W-1:0] in1,
    input  logic [SH_W-1:0]   sh,
    input  sh_mode_e          mode,
    output logic [DATA_W-1:0] shifted
);

    logic [DATA_W-1:0] l_stage [SH_W+1];
    logic [DATA_W-1:0] r_stage [SH_W+1];
    logic              fill;

    // Only arithmetic right shifts replicate the sign bit.
    assign fill       = (mode == SH_SRA) ? in1[DATA_W-1] : 1'b0;
    assign l_stage[0] = in1;
    assign r_stage[0] = in1;

    generate
        for (genvar gi = 0; gi < SH_W; gi++) begin : g_stage
            localparam int STEP = 1 << gi;
            assign l_stage[gi+1] = sh[gi]
                ? {l_stage[gi][DATA_W-1-STEP:0], {STEP{1'b0}}}
                : l_stage[gi];
            assign r_stage[gi+1] = sh[gi]
                ? {{STEP{fill}}, r_stage[gi][DATA_W-1:STEP]}
                : r_stage[gi];
        end
    endgenerate

    assign shifted = (mode == SH_SLL) ? l_stage[SH_W] : r_stage[SH_W];

endmodule

// File: rtl/alu_unit.sv
// 32-bit execute-stage ALU with a single registered output stage (1-cycle latency).
// Optional status flags (zero/ovf/carry) are enabled by defining ALU_STATUS_FLAGS_EN.
module alu_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int IMM_W  = alu_pkg::IMM_W,
    parameter int SH_W   = alu_pkg::SH_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [IMM_W-1:0]  imm,
    input  logic [SH_W-1:0]   sh,
    input  logic [OP_W-1:0]   alu_op,
    output logic              out_valid,
    output logic [DATA_W-1:0] result
`ifdef ALU_STATUS_FLAGS_EN
    ,
    output logic              zero,
    output logic              ovf,
    output logic              carry
`endif
);

    alu_op_e           op;
    sh_mode_e          sh_mode;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] add_b;
    logic              add_cin;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] result_next;

    assign op       = alu_op_e'(alu_op);
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};

    // One shared adder: SUB is in1 + ~in2 + 1, so its carry-out is borrow-not.
    always_comb begin
        add_b   = in2;
        add_cin = 1'b0;
        case (op)
            ALU_SUB: begin
                add_b   = ~in2;
                add_cin = 1'b1;
            end
            ALU_ADDI: add_b = imm_sext;
            default:  add_b = in2;
        endcase
    end

    assign sum_ext = {1'b0, in1} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};

    always_comb begin
        sh_mode = SH_SLL;
        case (op)
            ALU_SRL: sh_mode = SH_SRL;
            ALU_SRA: sh_mode = SH_SRA;
            default: sh_mode = SH_SLL;
        endcase
    end

    alu_shifter #(
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_shifter (
        .in1     (in1),
        .sh      (sh),
        .mode    (sh_mode),
        .shifted (shifted)
    );

    always_comb begin
        result_next = '0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_ADDI: result_next = sum_ext[DATA_W-1:0];
            ALU_OR:                     result_next = in1 | in2;
            ALU_ORI:                    result_next = in1 | imm_zext;
            ALU_SLL, ALU_SRL, ALU_SRA:  result_next = shifted;
            default:                    result_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            result    <= result_next;
            out_valid <= in_valid;
        end
    end

`ifdef ALU_STATUS_FLAGS_EN
    logic is_arith;
    logic ovf_next;

    assign is_arith = (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_ADDI);
    // Signed overflow: both adder inputs share a sign that the sum does not.
    assign ovf_next = is_arith
                   && (in1[DATA_W-1] == add_b[DATA_W-1])
                   && (sum_ext[DATA_W-1] != in1[DATA_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero  <= 1'b0;
            ovf   <= 1'b0;
            carry <= 1'b0;
        end else begin
            zero  <= (result_next == '0);
            ovf   <= ovf_next;
            carry <= is_arith & sum_ext[DATA_W];
        end
    end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors plus a randomized stream
// checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in1, in2;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic [2:0]  alu_op;
    logic        out_valid;
    logic [31:0] result;
`ifdef ALU_STATUS_FLAGS_EN
    logic        zero, ovf, carry;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .imm       (imm),
        .sh        (sh),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .result    (result)
`ifdef ALU_STATUS_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf),
        .carry     (carry)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model straight from the opcode table.
    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [15:0] i,
                                                 input logic [4:0] s);
        logic [31:0] isx;
        isx = 32'($signed(i));
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a + isx;
            3'd3: return a | b;
            3'd4: return a | {16'h0000, i};
            3'd5: return a << s;
            3'd6: return a >> s;
            default: return 32'($signed(a) >>> s);
        endcase
    endfunction

    // Flags as {zero, ovf, carry}, from wide signed/unsigned arithmetic.
    function automatic logic [2:0] model_flags(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [15:0] i,
                                               input logic [4:0] s);
        longint sa, sb, sr;
        longint unsigned ua, ub;
        logic o, c, z;
        sa = longint'($signed(a));
        ua = {32'h0, a};
        o  = 1'b0;
        c  = 1'b0;
        z  = (model_result(op, a, b, i, s) == 32'h0);
        if (op == 3'd0 || op == 3'd2) begin
            sb = (op == 3'd0) ? longint'($signed(b)) : longint'($signed(i));
            ub = {32'h0, ((op == 3'd0) ? b : 32'($signed(i)))};
            sr = sa + sb;
            o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            c  = (ua + ub) > 64'd4294967295;
        end else if (op == 3'd1) begin
            sr = sa - longint'($signed(b));
            o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            c  = (ua >= {32'h0, b});
        end
        return {z, o, c};
    endfunction

    logic [31:0] exp_result;
    logic        exp_valid;
    logic [2:0]  exp_flags;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_result <= 32'h0;
            exp_valid  <= 1'b0;
            exp_flags  <= 3'b000;
        end else begin
            exp_result <= model_result(alu_op, in1, in2, imm, sh);
            exp_valid  <= in_valid;
            exp_flags  <= model_flags(alu_op, in1, in2, imm, sh);
        end
    end

    // Continuous compare against the model, on the falling edge.
    always @(negedge clk) begin
        chk("cyc_valid", {31'h0, out_valid}, {31'h0, exp_valid});
        chk("cyc_result", result, exp_result);
`ifdef ALU_STATUS_FLAGS_EN
        chk("cyc_flags", {29'h0, zero, ovf, carry}, {29'h0, exp_flags});
`endif
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] i, input logic [4:0] s, input logic v);
        alu_op = op; in1 = a; in2 = b; imm = i; sh = s; in_valid = v;
    endtask

    // Apply one op just after an edge, then check the literal after the capturing edge.
    task automatic run_lit(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] i, input logic [4:0] s,
                           input logic [31:0] exp);
        @(posedge clk); #1;
        drive(op, a, b, i, s, 1'b1);
        @(posedge clk); #2;
        chk(name, result, exp);
        chk({name, "_v"}, {31'h0, out_valid}, 32'h1);
        $display("txn %s op=%0d in1=0x%08h in2=0x%08h imm=0x%04h sh=%0d -> 0x%08h",
                 name, op, a, b, i, s, result);
    endtask

    initial begin
        logic [31:0] specials [4];
        logic [31:0] base_exp [8];
        specials = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        base_exp = '{32'h0000_0002, 32'h0000_0008, 32'hFFFF_FFF9, 32'hFFFF_FFFD,
                     32'h0000_FFF5, 32'h0000_0014, 32'h0000_0001, 32'h0000_0001};

        rst = 1'b1;
        drive(3'd0, 32'h0, 32'h0, 16'h0, 5'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("reset_result", result, 32'h0);
        chk("reset_valid", {31'h0, out_valid}, 32'h0);
        #1 rst = 1'b0;

        for (int k = 0; k < 8; k++)
            run_lit($sformatf("base_op%0d", k), 3'(k), 32'd5, -32'sd3, 16'hFFF4, 5'd2, base_exp[k]);

        run_lit("srl_sign", 3'd6, 32'h8000_0000, 32'h0, 16'h0, 5'd4, 32'h0800_0000);
        run_lit("sra_sign", 3'd7, 32'h8000_0000, 32'h0, 16'h0, 5'd4, 32'hF800_0000);
        run_lit("sll_out",  3'd5, 32'h8000_0000, 32'h0, 16'h0, 5'd4, 32'h0000_0000);
        run_lit("sra_sh0",  3'd7, 32'h8000_0000, 32'h0, 16'h0, 5'd0, 32'h8000_0000);

        run_lit("add_wrap", 3'd0, 32'h7FFF_FFFF, 32'h1, 16'h0, 5'd0, 32'h8000_0000);
`ifdef ALU_STATUS_FLAGS_EN
        chk("add_wrap_flags", {29'h0, zero, ovf, carry}, 32'b010);
`endif
        run_lit("sub_zero", 3'd1, 32'd5, 32'd5, 16'h0, 5'd0, 32'h0);
`ifdef ALU_STATUS_FLAGS_EN
        chk("sub_zero_flags", {29'h0, zero, ovf, carry}, 32'b101);
`endif
        run_lit("ori_zext",  3'd4, 32'h0, 32'h0, 16'h8000, 5'd0, 32'h0000_8000);
        run_lit("addi_sext", 3'd2, 32'h0, 32'h0, 16'h8000, 5'd0, 32'hFFFF_8000);

        // Single-cycle valid pulse.
        @(posedge clk); #1;
        drive(3'd0, 32'd1, 32'd1, 16'h0, 5'd0, 1'b0);
        @(posedge clk); #1;
        drive(3'd0, 32'd2, 32'd3, 16'h0, 5'd0, 1'b1);
        @(posedge clk); #1;
        drive(3'd0, 32'd9, 32'd9, 16'h0, 5'd0, 1'b0);
        #1;
        chk("pulse_hi", {31'h0, out_valid}, 32'h1);
        chk("pulse_res", result, 32'd5);
        @(posedge clk); #2;
        chk("pulse_lo", {31'h0, out_valid}, 32'h0);
        chk("pulse_inv_res", result, 32'd18);

        // Asynchronous reset between edges while a valid result is held.
        run_lit("pre_rst", 3'd2, 32'd5, -32'sd3, 16'hFFF4, 5'd2, 32'hFFFF_FFF9);
        #1 rst = 1'b1;
        #1;
        chk("arst_result", result, 32'h0);
        chk("arst_valid", {31'h0, out_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        chk("arst_hold_result", result, 32'h0);
        chk("arst_hold_valid", {31'h0, out_valid}, 32'h0);
        #1 rst = 1'b0;

        // Randomized back-to-back stream, checked by the per-cycle compare.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            drive(3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom,
                  ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom,
                  16'($urandom), 5'($urandom), 1'($urandom));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #6;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
